// File: rtl/mir_pipe.sv
// -----------------------------------------------------------------------------
// mir_pipe -- microinstruction register pipeline for the EV22 microsequencer.
//
// A DEPTH-stage register chain carrying a WIDTH-bit microword plus a valid
// bit from the control store output to the datapath control decode. It adds:
// asynchronous reset, synchronous flush to NOP_WORD, a per-microword
// multi-cycle hold with back-pressure (BUSY), and a saturating stall counter.
//
// Ports:
//   CLK        in   1      clock, all state updates on the rising edge
//   nRESET     in   1      asynchronous active-low reset
//   UW_IN      in   WIDTH  microword from the control store
//   HOLD_IN    in   HW     extra cycles the microword stays at the output
//   VALID_IN   in   1      UW_IN/HOLD_IN are meaningful
//   nENABLE    in   1      active-low advance enable (high = global stall)
//   FLUSH      in   1      synchronous flush of all stages
//   UW_OUT     out  WIDTH  microword of the output stage (stage DEPTH-1)
//   VALID_OUT  out  1      output stage valid
//   BUSY       out  1      output stage in hold; upstream keeps UW_IN stable
//   STALLS     out  SCW    saturating count of stalled valid-output cycles
//
// Handshake: a word is taken from UW_IN/HOLD_IN/VALID_IN only on an edge
// where adv = !nENABLE && !BUSY && !FLUSH. On any other edge the upstream
// must keep those inputs stable; there is no separate ready signal.
//
// DEPTH must lie in 1..8.
// -----------------------------------------------------------------------------
module mir_pipe #(
   parameter int               WIDTH    = 43,
   parameter int               DEPTH    = 2,
   parameter int               HW       = 4,
   parameter logic [WIDTH-1:0] NOP_WORD = {WIDTH{1'b0}},
   parameter int               SCW      = 16
) (
   input  logic             CLK,
   input  logic             nRESET,
   input  logic [WIDTH-1:0] UW_IN,
   input  logic [HW-1:0]    HOLD_IN,
   input  logic             VALID_IN,
   input  logic             nENABLE,
   input  logic             FLUSH,
   output logic [WIDTH-1:0] UW_OUT,
   output logic             VALID_OUT,
   output logic             BUSY,
   output logic [SCW-1:0]   STALLS
);

   // Output-stage hold counter and stall counter.
   logic [HW-1:0]  hcnt_q, hcnt_d;
   logic [SCW-1:0] stalls_q, stalls_d;

   logic busy;
   logic adv;
   logic stall_edge;

   // Source of each stage: index 0 is the input port, index k is stage k-1.
   logic [WIDTH-1:0] src_word  [DEPTH];
   logic [HW-1:0]    src_hold  [DEPTH];
   logic             src_valid [DEPTH];

   logic [WIDTH-1:0] out_word;
   logic             out_valid;

   assign busy = (hcnt_q != '0);
   assign adv  = !nENABLE && !busy && !FLUSH;

   assign src_word[0]  = UW_IN;
   assign src_hold[0]  = HOLD_IN;
   assign src_valid[0] = VALID_IN;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [WIDTH-1:0] word_q, word_d;
      logic             valid_q, valid_d;

      // Invalid sources become bubbles: NOP_WORD with valid=0.
      always_comb begin
         word_d  = word_q;
         valid_d = valid_q;
         if (FLUSH) begin
            word_d  = NOP_WORD;
            valid_d = 1'b0;
         end else if (adv) begin
            valid_d = src_valid[k];
            word_d  = src_valid[k] ? src_word[k] : NOP_WORD;
         end
      end

      always_ff @(posedge CLK or negedge nRESET) begin
         if (!nRESET) begin
            word_q  <= NOP_WORD;
            valid_q <= 1'b0;
         end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
         end
      end

      if (k < DEPTH - 1) begin : g_mid
         // Intermediate stages carry the hold count forward. The output
         // stage has no hold register: its hold value lives in hcnt_q.
         logic [HW-1:0] hold_q, hold_d;

         always_comb begin
            hold_d = hold_q;
            if (FLUSH) begin
               hold_d = '0;
            end else if (adv) begin
               hold_d = src_valid[k] ? src_hold[k] : '0;
            end
         end

         always_ff @(posedge CLK or negedge nRESET) begin
            if (!nRESET) begin
               hold_q <= '0;
            end else begin
               hold_q <= hold_d;
            end
         end

         assign src_word[k+1]  = word_q;
         assign src_hold[k+1]  = hold_q;
         assign src_valid[k+1] = valid_q;
      end else begin : g_last
         assign out_word  = word_q;
         assign out_valid = valid_q;
      end
   end

   // hcnt loads the hold of the word entering the output stage and counts
   // down only on enabled, non-advancing edges; it never wraps because it
   // only decrements while nonzero.
   always_comb begin
      hcnt_d = hcnt_q;
      if (FLUSH) begin
         hcnt_d = '0;
      end else if (adv) begin
         hcnt_d = src_valid[DEPTH-1] ? src_hold[DEPTH-1] : '0;
      end else if (!nENABLE && busy) begin
         hcnt_d = hcnt_q - HW'(1);
      end
   end

   // A stalled cycle is one where a valid word sits at the output and cannot
   // move, either from the global stall or its own hold. Flush edges excluded.
   assign stall_edge = !FLUSH && out_valid && (nENABLE || busy);

   always_comb begin
      stalls_d = stalls_q;
      if (stall_edge && (stalls_q != '1)) begin
         stalls_d = stalls_q + SCW'(1);
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         hcnt_q   <= '0;
         stalls_q <= '0;
      end else begin
         hcnt_q   <= hcnt_d;
         stalls_q <= stalls_d;
      end
   end

   assign UW_OUT    = out_word;
   assign VALID_OUT = out_valid;
   assign BUSY      = busy;
   assign STALLS    = stalls_q;

endmodule

// File: tb/tb_mir_pipe.sv
// -----------------------------------------------------------------------------
// tb_mir_pipe -- directed, table-driven bench for mir_pipe.
// Three instances share the inputs: DEPTH=2 (main), DEPTH=3 (bubble checks)
// and DEPTH=2 with a 4-bit stall counter (saturation checks).
// -----------------------------------------------------------------------------
module tb_mir_pipe;

   localparam int W = 43;

   logic          CLK;
   logic          nRESET;
   logic [W-1:0]  UW_IN;
   logic [3:0]    HOLD_IN;
   logic          VALID_IN;
   logic          nENABLE;
   logic          FLUSH;

   logic [W-1:0]  uw2, uw3, uws;
   logic          v2, v3, vs;
   logic          b2, b3, bs;
   logic [15:0]   st2, st3;
   logic [3:0]    sts;

   int tests_run = 0;
   int tests_failed = 0;

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   mir_pipe #(.WIDTH(W), .DEPTH(2), .HW(4), .SCW(16)) dut (
      .CLK(CLK), .nRESET(nRESET), .UW_IN(UW_IN), .HOLD_IN(HOLD_IN),
      .VALID_IN(VALID_IN), .nENABLE(nENABLE), .FLUSH(FLUSH),
      .UW_OUT(uw2), .VALID_OUT(v2), .BUSY(b2), .STALLS(st2));

   mir_pipe #(.WIDTH(W), .DEPTH(3), .HW(4), .SCW(16)) dut3 (
      .CLK(CLK), .nRESET(nRESET), .UW_IN(UW_IN), .HOLD_IN(HOLD_IN),
      .VALID_IN(VALID_IN), .nENABLE(nENABLE), .FLUSH(FLUSH),
      .UW_OUT(uw3), .VALID_OUT(v3), .BUSY(b3), .STALLS(st3));

   mir_pipe #(.WIDTH(W), .DEPTH(2), .HW(4), .SCW(4)) dut_s (
      .CLK(CLK), .nRESET(nRESET), .UW_IN(UW_IN), .HOLD_IN(HOLD_IN),
      .VALID_IN(VALID_IN), .nENABLE(nENABLE), .FLUSH(FLUSH),
      .UW_OUT(uws), .VALID_OUT(vs), .BUSY(bs), .STALLS(sts));

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic vin, input logic [W-1:0] uw,
                        input logic [3:0] hold, input logic nen,
                        input logic flush);
      VALID_IN = vin;
      UW_IN    = uw;
      HOLD_IN  = hold;
      nENABLE  = nen;
      FLUSH    = flush;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 4'd0, 1'b0, 1'b0);
      nRESET = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      @(negedge CLK);
      nRESET = 1'b1;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string name, input int idx,
                        input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s[%0d]: got 'h%0h, required 'h%0h", name, idx, act, exp);
      end
   endtask

   task automatic check_out2(input string name, input int idx,
                             input logic [W-1:0] e_uw, input logic e_v,
                             input logic e_b, input logic [15:0] e_st);
      check({name, "_uw"}, idx, 64'(uw2), 64'(e_uw));
      check({name, "_valid"}, idx, 64'(v2), 64'(e_v));
      check({name, "_busy"}, idx, 64'(b2), 64'(e_b));
      check({name, "_stalls"}, idx, 64'(st2), 64'(e_st));
   endtask

   // ---------------- vector table (DEPTH=2 instance) ----------------
   typedef struct {
      logic         vin;
      logic [W-1:0] uw;
      logic [3:0]   hold;
      logic         nen;
      logic [W-1:0] e_uw;
      logic         e_v;
      logic         e_b;
      logic [15:0]  e_st;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   localparam logic [W-1:0] WA = 43'h111, WB = 43'h222, WC = 43'h333;
   localparam logic [W-1:0] WD = 43'h444, WE = 43'h555, WF = 43'h666;

   initial begin
      // Each row: inputs applied before an edge, outputs required after it.
      tbl[0]  = '{1'b1, WA, 4'd0, 1'b0, '0, 1'b0, 1'b0, 16'd0}; // A captured
      tbl[1]  = '{1'b1, WB, 4'd0, 1'b0, WA, 1'b1, 1'b0, 16'd0}; // A out
      tbl[2]  = '{1'b1, WC, 4'd0, 1'b0, WB, 1'b1, 1'b0, 16'd0};
      tbl[3]  = '{1'b1, WD, 4'd3, 1'b0, WC, 1'b1, 1'b0, 16'd0}; // D has hold 3
      tbl[4]  = '{1'b1, WE, 4'd0, 1'b0, WD, 1'b1, 1'b1, 16'd0}; // D out, hcnt=3
      tbl[5]  = '{1'b1, WE, 4'd0, 1'b0, WD, 1'b1, 1'b1, 16'd1}; // hcnt=2
      tbl[6]  = '{1'b1, WE, 4'd0, 1'b0, WD, 1'b1, 1'b1, 16'd2}; // hcnt=1
      tbl[7]  = '{1'b1, WE, 4'd0, 1'b0, WD, 1'b1, 1'b0, 16'd3}; // hcnt=0, 4th cycle
      tbl[8]  = '{1'b1, WF, 4'd0, 1'b0, WE, 1'b1, 1'b0, 16'd3}; // adv: E out
      tbl[9]  = '{1'b1, WF, 4'd0, 1'b1, WE, 1'b1, 1'b0, 16'd4}; // global stall
      tbl[10] = '{1'b1, WF, 4'd0, 1'b1, WE, 1'b1, 1'b0, 16'd5};
      tbl[11] = '{1'b1, WF, 4'd0, 1'b1, WE, 1'b1, 1'b0, 16'd6};
      tbl[12] = '{1'b1, WF, 4'd0, 1'b1, WE, 1'b1, 1'b0, 16'd7};
      tbl[13] = '{1'b1, WF, 4'd0, 1'b1, WE, 1'b1, 1'b0, 16'd8};
      tbl[14] = '{1'b0, WA, 4'd0, 1'b0, WF, 1'b1, 1'b0, 16'd8}; // F out, bubble in
      tbl[15] = '{1'b0, WA, 4'd0, 1'b0, '0, 1'b0, 1'b0, 16'd8}; // bubble out
   end

   // ---------------- main sequence ----------------
   initial begin
      nRESET = 1'b0;
      drive(1'b0, '0, 4'd0, 1'b0, 1'b0);
      #2;
      // Reset state before any clock edge.
      check_out2("reset_state", 0, '0, 1'b0, 1'b0, 16'd0);

      // Table: streaming, hold, global stall, bubble.
      do_reset();
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].vin, tbl[i].uw, tbl[i].hold, tbl[i].nen, 1'b0);
         step();
         check_out2("vec", i, tbl[i].e_uw, tbl[i].e_v, tbl[i].e_b, tbl[i].e_st);
      end

      // Stall counting and saturation (16-bit and 4-bit instances).
      do_reset();
      drive(1'b1, WA, 4'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, WB, 4'd0, 1'b0, 1'b0);
      step();
      check_out2("stall_pre", 0, WA, 1'b1, 1'b0, 16'd0);
      drive(1'b1, WB, 4'd0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         step();
         check_out2("stall", i, WA, 1'b1, 1'b0, 16'(i));
      end
      for (int i = 6; i <= 22; i++) step();
      check("stall_frozen_uw", 0, 64'(uw2), 64'(WA));
      check("stall_cnt16", 0, 64'(st2), 64'd22);
      check("stall_sat4", 0, 64'(sts), 64'hF);
      step();
      check("stall_sat4_hold", 0, 64'(sts), 64'hF);

      // Flush during a hold (hcnt=2) with nENABLE=1.
      do_reset();
      drive(1'b1, WA, 4'd3, 1'b0, 1'b0);
      step();
      drive(1'b1, WB, 4'd0, 1'b0, 1'b0);
      step();
      check_out2("flush_hold3", 0, WA, 1'b1, 1'b1, 16'd0);
      step();
      check_out2("flush_hold2", 0, WA, 1'b1, 1'b1, 16'd1);
      drive(1'b1, WB, 4'd0, 1'b1, 1'b1);
      step();
      check_out2("flush_edge", 0, '0, 1'b0, 1'b0, 16'd1);
      drive(1'b0, WB, 4'd0, 1'b0, 1'b0);
      step();
      check_out2("flush_after", 0, '0, 1'b0, 1'b0, 16'd1);

      // Bubbles through the DEPTH=3 instance: A, invalid, B.
      do_reset();
      drive(1'b1, WA, 4'd0, 1'b0, 1'b0);
      step();
      drive(1'b0, 43'h5A5, 4'd0, 1'b0, 1'b0);
      step();
      drive(1'b1, WB, 4'd0, 1'b0, 1'b0);
      step();
      check("bub_a_uw", 0, 64'(uw3), 64'(WA));
      check("bub_a_v", 0, 64'(v3), 64'd1);
      drive(1'b0, 43'h5A5, 4'd0, 1'b0, 1'b0);
      step();
      check("bub_nop_uw", 0, 64'(uw3), 64'd0);
      check("bub_nop_v", 0, 64'(v3), 64'd0);
      step();
      check("bub_b_uw", 0, 64'(uw3), 64'(WB));
      check("bub_b_v", 0, 64'(v3), 64'd1);
      step();
      check("bub_end_v", 0, 64'(v3), 64'd0);

      // Asynchronous reset mid-hold with an all-ones word.
      do_reset();
      drive(1'b1, 43'h7FF_FFFF_FFFF, 4'd5, 1'b0, 1'b0);
      step();
      step();
      check_out2("rst_pre", 0, 43'h7FF_FFFF_FFFF, 1'b1, 1'b1, 16'd0);
      step();
      check("rst_pre_st", 0, 64'(st2), 64'd1);
      #2;
      nRESET = 1'b0;
      #1;
      check_out2("rst_async", 0, '0, 1'b0, 1'b0, 16'd0);
      check("rst_async_v3", 0, 64'(v3), 64'd0);
      step();
      nRESET = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
